// File: rtl/pc_fetch_seq_if.sv
// Fetch-sequencer bus: PC/mux loop, program-memory req/ack, decoder valid/ready.
// The master side is the sequencer; the slave side is memory, mux and decoder.
interface pc_fetch_seq_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned IW = 8,
  parameter int unsigned CW = 8
);
  logic [AW-1:0] next_pc;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc;
  logic          imem_req;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          halt;
  logic          running;
  logic [CW-1:0] retired;

  modport master (
    input  next_pc, imem_ack, imem_data, instr_ready, halt,
    output pc_inc, pc, imem_req, instr, instr_valid, running, retired
  );

  modport slave (
    output next_pc, imem_ack, imem_data, instr_ready, halt,
    input  pc_inc, pc, imem_req, instr, instr_valid, running, retired
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// Program-counter and instruction-fetch sequencer: one fetch per instruction,
// handed to the decoder, with the next PC taken from the external address mux.
module pc_fetch_seq #(
  parameter int unsigned AW = 4,
  parameter int unsigned IW = 8,
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_seq_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [CW-1:0] retired_q, retired_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; halt is only sampled when no fetch is in flight.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: begin
        state_d = bus.halt ? HALTED : FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d      = bus.next_pc;
          retired_d = retired_q + CW'(1);
          state_d   = bus.halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        if (!bus.halt) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_inc      = AW'(pc_q + AW'(1));
  assign bus.instr       = instr_q;
  assign bus.retired     = retired_q;
  assign bus.imem_req    = (state_q == FETCH);
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.running     = (state_q == FETCH) || (state_q == HOLD);

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Self-checking bench for pc_fetch_seq: program memory model, expected-instruction
// scoreboard and a bench-side PC/retired model.
module tb_pc_fetch_seq;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset;

  pc_fetch_seq_if #(.AW(AW), .IW(IW), .CW(CW)) bus ();

  pc_fetch_seq #(.AW(AW), .IW(IW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [16];
  assign bus.imem_data = mem[bus.pc];

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [IW-1:0] exp_q [$];
  logic [AW-1:0] model_pc;
  logic [CW-1:0] model_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full instruction from FETCH: ack after ack_dly waits, accept after rdy_dly waits.
  task automatic do_instr(input int ack_dly, input int rdy_dly, input logic jump,
                          input logic [AW-1:0] tgt, input logic hlt);
    logic [IW-1:0] exp_i;
    logic [AW-1:0] nxt;
    bus.halt = hlt;
    chk("fetch_pc", 32'(bus.pc), 32'(model_pc));
    chk("fetch_req", 32'(bus.imem_req), 32'(1));
    for (int i = 0; i < ack_dly; i++) begin
      bus.imem_ack = 1'b0;
      step();
      chk("wait_req", 32'(bus.imem_req), 32'(1));
      chk("wait_pc", 32'(bus.pc), 32'(model_pc));
    end
    bus.imem_ack = 1'b1;
    exp_q.push_back(mem[model_pc]);
    step();
    bus.imem_ack = 1'b0;
    chk("hold_valid", 32'(bus.instr_valid), 32'(1));
    chk("hold_req", 32'(bus.imem_req), 32'(0));
    exp_i = exp_q.pop_front();
    chk("instr", 32'(bus.instr), 32'(exp_i));
    for (int i = 0; i < rdy_dly; i++) begin
      bus.instr_ready = 1'b0;
      step();
      chk("bp_valid", 32'(bus.instr_valid), 32'(1));
      chk("bp_instr", 32'(bus.instr), 32'(exp_i));
      chk("bp_pc", 32'(bus.pc), 32'(model_pc));
    end
    chk("pc_inc", 32'(bus.pc_inc), 32'(AW'(model_pc + AW'(1))));
    nxt = jump ? tgt : AW'(model_pc + AW'(1));
    bus.next_pc     = nxt;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    model_pc  = nxt;
    model_ret = model_ret + CW'(1);
    chk("acc_pc", 32'(bus.pc), 32'(model_pc));
    chk("retired", 32'(bus.retired), 32'(model_ret));
    chk("acc_running", 32'(bus.running), 32'(!hlt));
    chk("acc_req", 32'(bus.imem_req), 32'(!hlt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = IW'(8'hA0 + i);
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
    bus.halt        = 1'b0;
    bus.next_pc     = '0;
    reset           = 1'b1;
    model_pc        = '0;
    model_ret       = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(bus.pc), 32'(0));
    chk("rst_req", 32'(bus.imem_req), 32'(0));
    chk("rst_valid", 32'(bus.instr_valid), 32'(0));
    chk("rst_instr", 32'(bus.instr), 32'(0));
    chk("rst_retired", 32'(bus.retired), 32'(0));
    chk("rst_running", 32'(bus.running), 32'(0));

    reset = 1'b0;
    step();
    chk("start_req", 32'(bus.imem_req), 32'(1));
    chk("start_running", 32'(bus.running), 32'(1));

    // Sequential run 0..3, then jump to 14 and wrap through 15 -> 0.
    for (int i = 0; i < 4; i++) do_instr(0, 0, 1'b0, '0, 1'b0);
    chk("retired4", 32'(bus.retired), 32'(4));
    do_instr(0, 0, 1'b1, AW'(14), 1'b0);
    do_instr(0, 0, 1'b0, '0, 1'b0);
    do_instr(0, 0, 1'b0, '0, 1'b0);
    chk("wrap_pc", 32'(bus.pc), 32'(0));
    do_instr(0, 0, 1'b0, '0, 1'b0);
    do_instr(0, 0, 1'b0, '0, 1'b0);

    // Jump from pc=2 to 9, then wait states and backpressure at 9.
    do_instr(0, 0, 1'b1, AW'(9), 1'b0);
    do_instr(3, 2, 1'b0, '0, 1'b0);

    // Halt raised during the fetch at pc=5.
    do_instr(0, 0, 1'b1, AW'(5), 1'b0);
    do_instr(1, 1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'b1;
      step();
      chk("halted_running", 32'(bus.running), 32'(0));
      chk("halted_req", 32'(bus.imem_req), 32'(0));
      chk("halted_pc", 32'(bus.pc), 32'(6));
      chk("halted_valid", 32'(bus.instr_valid), 32'(0));
    end
    bus.imem_ack = 1'b0;
    bus.halt     = 1'b0;
    step();
    do_instr(0, 0, 1'b1, AW'(5), 1'b0);

    // Reset asserted between edges while holding instruction 8'hA5.
    bus.imem_ack = 1'b1;
    exp_q.push_back(mem[model_pc]);
    step();
    bus.imem_ack = 1'b0;
    chk("pre_rst_instr", 32'(bus.instr), 32'(exp_q.pop_front()));
    chk("pre_rst_valid", 32'(bus.instr_valid), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(bus.instr_valid), 32'(0));
    chk("async_instr", 32'(bus.instr), 32'(0));
    chk("async_pc", 32'(bus.pc), 32'(0));
    chk("async_retired", 32'(bus.retired), 32'(0));
    chk("async_req", 32'(bus.imem_req), 32'(0));
    @(negedge clk);
    bus.imem_ack = 1'b1;
    step();
    step();
    chk("stray_instr", 32'(bus.instr), 32'(0));
    chk("stray_valid", 32'(bus.instr_valid), 32'(0));
    reset        = 1'b0;
    bus.imem_ack = 1'b0;
    step();
    chk("post_rst_req", 32'(bus.imem_req), 32'(1));
    chk("post_rst_pc", 32'(bus.pc), 32'(0));
    chk("post_rst_instr", 32'(bus.instr), 32'(0));
    chk("post_rst_valid", 32'(bus.instr_valid), 32'(0));
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
Program-counter and instruction-fetch sequencer for the micro-processor. It holds the 4-bit PC and drives pc_inc into d0 of the program-memory 2:1 address mux. It loads the mux output y back as the next PC. It runs a req/ack fetch handshake to program memory and a valid/ready handshake to the decoder.

Parameters:
AW, 4, PC / program-memory address width (matches mux data width)
IW, 8, instruction word width
CW, 8, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
next_pc  input  AW  next PC from the 2:1 mux output y
pc_inc  output  AW  pc+1 mod 2^AW, drives mux input d0
pc  output  AW  current PC, program-memory address
imem_req  output  1  fetch request to program memory
imem_ack  input  1  program memory has data this cycle
imem_data  input  IW  instruction word, valid when imem_ack=1
instr  output  IW  registered instruction to decoder
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decoder accepts instr this cycle
halt  input  1  stop fetching after current instruction
running  output  1  1 in FETCH/HOLD, 0 in IDLE/HALTED
retired  output  CW  count of instructions accepted by decoder

Behaviour:
- Async reset (reset=1, any time, including mid-fetch): pc=0, instr=0, instr_valid=0, imem_req=0, retired=0, state=IDLE. An outstanding request is abandoned. A late imem_ack after reset is ignored.
- pc_inc is combinational: (pc+1) truncated to AW bits. pc=15 gives pc_inc=0. All other outputs are registered or decoded from state only.
- imem_req=1 exactly when state=FETCH. running=1 when state is FETCH or HOLD. instr_valid=1 exactly when state=HOLD.
- States: IDLE, FETCH, HOLD, HALTED.
- IDLE: on the first clk edge with reset=0, go to HALTED if halt=1, else go to FETCH.
- FETCH: pc is stable and imem_req=1.
  - On a clk edge with imem_ack=1: instr<=imem_data, go to HOLD.
  - With imem_ack=0: stay in FETCH, no limit on wait cycles.
  - halt is ignored in FETCH; an issued fetch always completes.
- HOLD: instr and pc are stable.
  - On a clk edge with instr_ready=1: pc<=next_pc, retired<=retired+1 (wraps mod 2^CW). Then go to HALTED if halt=1, else go to FETCH.
  - With instr_ready=0: stay in HOLD, no change to any register.
- HALTED: imem_req=0, pc holds. On a clk edge with halt=0, go to FETCH. The first fetch after un-halting uses the held pc.
- next_pc is sampled only on the HOLD-accept edge. The controller must drive the mux select s in that cycle, with s=0 for sequential and s=1 for jump.
- imem_ack outside FETCH: ignored, no state or register change.
- Simultaneous events:
  - instr_ready=1 with halt=1 in HOLD: the instruction is accepted and the PC updated, then the block goes to HALTED.
  - imem_ack=1 with halt=1 in FETCH: the data is captured and the block goes to HOLD.
- Throughput:
  - Best case is one instruction per 2 cycles: FETCH with ack, then HOLD with ready.
  - Minimum latency from reset release to first instr_valid=1 is 2 edges: IDLE to FETCH, then FETCH to HOLD with ack=1.

Test Plan:
- Reset then sequential run: reset pulse; hold ack=1 and ready=1; drive next_pc=pc_inc. Required: pc sequence 0,1,2,3. instr equals imem_data of each address. retired reaches 4 after 8 edges in FETCH/HOLD.
- Wrap-around: run sequentially from pc=14. Required: pc_inc=15 then 0, pc goes 14→15→0, and retired increments each accept.
- Jump: in HOLD at pc=2, drive next_pc=9 (mux s=1, d1=9) with instr_ready=1. Required: the next FETCH has pc=9 and imem_req=1.
- Wait states and backpressure: ack delayed 3 cycles, then ready delayed 2 cycles. Required: imem_req stays 1 for 4 cycles. instr_valid stays 1 with instr stable for 3 cycles. pc is unchanged until the accept edge.
- Halt handling:
  - Assert halt during FETCH at pc=5: the fetch still completes. On accept, pc loads next_pc=6, the block enters HALTED, running=0 and imem_req=0.
  - Deassert halt: the next fetch is at pc=6.
- Reset mid-operation: assert reset asynchronously while in HOLD with instr=8'hA5. Required, immediately and without waiting for clk: instr_valid=0, instr=0, pc=0, retired=0, imem_req=0. A later stray imem_ack=1 has no effect.
